// File: rtl/tinyalu_pkg.sv
// Shared TinyALU types: opcode encoding, arbiter FSM states,
// and the legality check for requester opcodes.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        NOP,
        RST,
        RESP
    } arb_state_t;

    // 3'b101 and 3'b110 have no ALU meaning.
    function automatic logic is_legal_op(input logic [2:0] op);
        return !((op == 3'b101) || (op == 3'b110));
    endfunction

endpackage

// File: rtl/tinyalu_rr_picker.sv
// Round-robin one-hot pick: first valid at or after ptr_i, wrapping.
// Ports: valid_i/ptr_i in; grant_o (one-hot or 0) and id_o out.
module tinyalu_rr_picker #(
    parameter int NUM_REQ = 4,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IW-1:0]      id_o
);

    // Walk from farthest to nearest so the nearest valid wins.
    always_comb begin
        int idx;
        grant_o = '0;
        id_o    = '0;
        idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_i) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (valid_i[IW'(idx)]) begin
                grant_o          = '0;
                grant_o[IW'(idx)] = 1'b1;
                id_o             = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/tinyalu_arbiter.sv
// Round-robin sharing of one TinyALU among NUM_REQ requesters.
// Ports: req_* command side, rsp_* response pulse, alu_* ALU pins.
module tinyalu_arbiter
    import tinyalu_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 16,
    parameter int RST_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic [NUM_REQ*8-1:0] req_a_i,
    input  logic [NUM_REQ*8-1:0] req_b_i,
    input  logic [NUM_REQ*3-1:0] req_op_i,
    output logic [NUM_REQ-1:0]   rsp_valid_o,
    output logic [15:0]          rsp_result_o,
    output logic                 rsp_err_o,
    output logic [7:0]           alu_a_o,
    output logic [7:0]           alu_b_o,
    output logic [2:0]           alu_op_o,
    output logic                 alu_start_o,
    output logic                 alu_reset_n_o,
    input  logic                 alu_done_i,
    input  logic [15:0]          alu_result_i
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + RST_CYCLES + 1);

    arb_state_t         state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d, id_q, id_d, pick_id;
    logic [NUM_REQ-1:0] pick_oh;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [15:0]        res_q, res_d;
    logic               err_q, err_d;
    logic               accept, legal;
    logic [7:0]         a_sel, b_sel;
    logic [2:0]         op_sel;

    logic [7:0]         alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic               alu_start_q, alu_start_d;
    logic               alu_rstn_q, alu_rstn_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [15:0]        rsp_result_q, rsp_result_d;
    logic               rsp_err_q, rsp_err_d;

    tinyalu_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (pick_oh),
        .id_o    (pick_id)
    );

    assign req_ready_o = (state_q == IDLE && !reset_i) ? pick_oh : '0;
    assign accept      = (state_q == IDLE) && (|pick_oh);
    assign legal       = is_legal_op(op_sel);

    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        op_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_id == IW'(i)) begin
                a_sel  = req_a_i[i*8 +: 8];
                b_sel  = req_b_i[i*8 +: 8];
                op_sel = req_op_i[i*3 +: 3];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Done is checked before the watchdog, so a same-cycle done wins.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!legal)                           state_d = RESP;
                    else if (op_sel == 3'(no_op))         state_d = NOP;
                    else if (op_sel == 3'(rst_op))        state_d = RST;
                    else                                  state_d = EXEC;
                end
            end
            EXEC: begin
                if (alu_done_i)                           state_d = RESP;
                else if (cnt_q == CW'(TIMEOUT - 1))       state_d = RST;
            end
            NOP:     state_d = RESP;
            RST: begin
                if (cnt_q == CW'(RST_CYCLES - 1))         state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
    end

    // Output registers load from next state so ALU pins track it.
    always_comb begin
        ptr_d    = ptr_q;
        id_d     = id_q;
        res_d    = res_q;
        err_d    = err_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        if (accept) begin
            id_d  = pick_id;
            ptr_d = (pick_id == IW'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
            res_d = '0;
            err_d = !legal;
            if (legal) begin
                alu_a_d  = a_sel;
                alu_b_d  = b_sel;
                alu_op_d = op_sel;
            end
        end
        if (state_q == EXEC && alu_done_i) res_d = alu_result_i;
        if (state_q == EXEC && state_d == RST) err_d = 1'b1;
        if (state_q == RESP) err_d = 1'b0;

        alu_start_d = (state_d == EXEC) || (state_d == NOP);
        alu_rstn_d  = (state_d != RST);

        rsp_valid_d = '0;
        if (state_q == RESP) rsp_valid_d[id_q] = 1'b1;
        rsp_result_d = (state_q == RESP) ? res_q : '0;
        rsp_err_d    = (state_q == RESP) && err_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q        <= '0;
            id_q         <= '0;
            res_q        <= '0;
            err_q        <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= 3'(no_op);
            alu_start_q  <= 1'b0;
            alu_rstn_q   <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            res_q        <= res_d;
            err_q        <= err_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            alu_start_q  <= alu_start_d;
            alu_rstn_q   <= alu_rstn_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_a_o       = alu_a_q;
    assign alu_b_o       = alu_b_q;
    assign alu_op_o      = alu_op_q;
    assign alu_start_o   = alu_start_q;
    assign alu_reset_n_o = alu_rstn_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_result_o  = rsp_result_q;
    assign rsp_err_o     = rsp_err_q;

endmodule
